bp_table_sequencer: RTL and testbench

- Sequences every access to the single-ported branch-history table of 2-bit saturating counters.
- Arbitrates between two requesters:
  - IF-stage prediction lookups.
  - ID-stage outcome updates, which are buffered and applied as read-modify-write.
- Owns the post-reset / flush sweep that clears the table.
- Sits between the IF/ID pipeline stages and the table RAM, so predictor updates never need a second table port.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_upd_fifo.sv | 57 +++++
 rtl/bp_table_sequencer.sv | 141 ++++++++++++++
 tb/tb_bp_table_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-history table sequencer:
// FSM state encoding, 2-bit counter constants and the saturating update.
package bp_pkg;

    localparam int BP_IDX_W = 7;
    localparam int BP_CTR_W = 2;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_WRITE
    } bp_state_e;

    localparam logic [BP_CTR_W-1:0] CTR_SNT = 2'd0;
    localparam logic [BP_CTR_W-1:0] CTR_WNT = 2'd1;
    localparam logic [BP_CTR_W-1:0] CTR_WT  = 2'd2;
    localparam logic [BP_CTR_W-1:0] CTR_ST  = 2'd3;

    function automatic logic [BP_CTR_W-1:0] sat_update(input logic [BP_CTR_W-1:0] ctr,
                                                       input logic                taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small FIFO buffering resolved-branch updates ({idx, taken}) until the
// sequencer finds a free table slot for their read-modify-write.
module bp_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/bp_table_sequencer.sv
// Owns the single port of the branch-history table: clear sweep, IF lookups
// and buffered ID updates applied as read-then-write.
module bp_table_sequencer
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int DEPTH = 4,
    parameter int CTR_W = BP_CTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_req,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_gnt,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    input  logic             flush_req,
    output logic             busy_init,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [CTR_W-1:0] tbl_wdata,
    input  logic [CTR_W-1:0] tbl_rdata
);

    localparam logic [IDX_W-1:0] INIT_LAST = '1;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             pred_valid_q;

    logic             fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [IDX_W:0]   fifo_head;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic             tbl_en_c, tbl_we_c, enter_init;

    assign head_idx   = fifo_head[IDX_W:1];
    assign head_taken = fifo_head[0];
    assign upd_ready  = !fifo_full && (state_q != S_INIT);
    assign fifo_push  = upd_valid && upd_ready;
    assign fifo_clr   = enter_init;

    bp_upd_fifo #(.W(IDX_W + 1), .DEPTH(DEPTH)) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .din   ({upd_idx, upd_taken}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        flush_pend_d = flush_pend_q;
        tbl_en_c     = 1'b0;
        tbl_we_c     = 1'b0;
        tbl_addr     = '0;
        tbl_wdata    = '0;
        lookup_gnt   = 1'b0;
        fifo_pop     = 1'b0;
        enter_init   = 1'b0;

        unique case (state_q)
            S_INIT: begin
                tbl_en_c   = 1'b1;
                tbl_we_c   = 1'b1;
                tbl_addr   = init_cnt_q;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (flush_req)                    enter_init = 1'b1;
                else if (init_cnt_q == INIT_LAST) state_d    = S_RUN;
            end
            S_RUN: begin
                // A full FIFO outranks lookups so updates cannot starve forever.
                if (fifo_full) begin
                    tbl_en_c = 1'b1;
                    tbl_addr = head_idx;
                    state_d  = S_WRITE;
                end else if (lookup_req) begin
                    tbl_en_c   = 1'b1;
                    tbl_addr   = lookup_idx;
                    lookup_gnt = 1'b1;
                end else if (!fifo_empty) begin
                    tbl_en_c = 1'b1;
                    tbl_addr = head_idx;
                    state_d  = S_WRITE;
                end
                if (flush_req) enter_init = 1'b1;
            end
            S_WRITE: begin
                tbl_en_c  = 1'b1;
                tbl_we_c  = 1'b1;
                tbl_addr  = head_idx;
                tbl_wdata = sat_update(tbl_rdata, head_taken);
                fifo_pop  = 1'b1;
                state_d   = S_RUN;
                if (flush_req) flush_pend_d = 1'b1;
                if (flush_req || flush_pend_q) enter_init = 1'b1;
            end
            default: state_d = S_INIT;
        endcase

        if (enter_init) begin
            state_d      = S_INIT;
            init_cnt_d   = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            flush_pend_q <= flush_pend_d;
            pred_valid_q <= lookup_gnt;
        end
    end

    // The port stays quiet while reset is held, even though the reset state is the sweep.
    assign tbl_en     = tbl_en_c && rst_n;
    assign tbl_we     = tbl_we_c && rst_n;
    assign busy_init  = (state_q == S_INIT);
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_valid_q && tbl_rdata[CTR_W-1];

endmodule

// File: tb/tb_bp_table_sequencer.sv
// Self-checking bench: table RAM model, cycle-level reference model with a
// prediction scoreboard, directed scenarios followed by random traffic.
module tb_bp_table_sequencer;

    localparam int IDX_W = 7;
    localparam int DEPTH = 4;
    localparam int CTR_W = 2;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lookup_req, upd_valid, upd_taken, flush_req;
    logic [IDX_W-1:0] lookup_idx, upd_idx;
    logic             lookup_gnt, pred_valid, pred_taken, upd_ready, busy_init;
    logic             tbl_en, tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [CTR_W-1:0] tbl_wdata, tbl_rdata;

    always #5 clk = ~clk;

    bp_table_sequencer #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_req (lookup_req),
        .lookup_idx (lookup_idx),
        .lookup_gnt (lookup_gnt),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .flush_req  (flush_req),
        .busy_init  (busy_init),
        .tbl_en     (tbl_en),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .tbl_rdata  (tbl_rdata)
    );

    // Single-ported table RAM with registered read data.
    logic [CTR_W-1:0] ram [N];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) ram[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= ram[tbl_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    upd_t m_q[$];
    int   m_ctr[N];
    int   m_sweep_left;
    bit   m_wb;
    bit   m_pred_due;
    bit   exp_pred_q[$];

    function automatic int ref_sat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_step();
        bit   e_gnt, e_ready, e_en, start_sweep;
        int   e_addr, nv;
        upd_t h, u;
        start_sweep = 0;
        e_gnt       = 0;
        check("pred_valid", pred_valid, m_pred_due);
        check("busy_init", busy_init, m_sweep_left > 0);
        if (m_sweep_left > 0) begin
            e_addr = N - m_sweep_left;
            check("sweep_gnt", lookup_gnt, 0);
            check("sweep_ready", upd_ready, 0);
            check("sweep_en_we", {tbl_en, tbl_we}, 2'b11);
            check("sweep_addr", tbl_addr, e_addr);
            check("sweep_wdata", tbl_wdata, 0);
            m_ctr[e_addr] = 0;
            m_pred_due    = 0;
            if (flush_req) m_sweep_left = N;
            else           m_sweep_left--;
        end else if (m_wb) begin
            h       = m_q[0];
            nv      = ref_sat(m_ctr[h.idx], h.taken);
            e_ready = (m_q.size() < DEPTH);
            check("wr_gnt", lookup_gnt, 0);
            check("wr_ready", upd_ready, e_ready);
            check("wr_en_we", {tbl_en, tbl_we}, 2'b11);
            check("wr_addr", tbl_addr, h.idx);
            check("wr_wdata", tbl_wdata, nv);
            m_ctr[h.idx] = nv;
            void'(m_q.pop_front());
            m_wb       = 0;
            m_pred_due = 0;
            if (upd_valid && e_ready) begin
                u.idx = upd_idx; u.taken = upd_taken; m_q.push_back(u);
            end
            if (flush_req) start_sweep = 1;
        end else begin
            e_ready = (m_q.size() < DEPTH);
            e_addr  = 0;
            if (m_q.size() == DEPTH) begin
                m_wb = 1; e_addr = m_q[0].idx;
            end else if (lookup_req) begin
                e_gnt = 1; e_addr = lookup_idx;
                exp_pred_q.push_back(m_ctr[lookup_idx] >= 2);
            end else if (m_q.size() > 0) begin
                m_wb = 1; e_addr = m_q[0].idx;
            end
            e_en = e_gnt || m_wb;
            check("run_gnt", lookup_gnt, e_gnt);
            check("run_ready", upd_ready, e_ready);
            check("run_en", tbl_en, e_en);
            if (e_en) begin
                check("run_we", tbl_we, 0);
                check("run_addr", tbl_addr, e_addr);
            end
            m_pred_due = e_gnt;
            if (upd_valid && e_ready) begin
                u.idx = upd_idx; u.taken = upd_taken; m_q.push_back(u);
            end
            if (flush_req) start_sweep = 1;
        end
        if (start_sweep) begin
            m_sweep_left = N;
            m_q.delete();
            m_wb = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy_init, 1);
            check("rst_gnt_ready", {lookup_gnt, upd_ready}, 2'b00);
            check("rst_en_we", {tbl_en, tbl_we}, 2'b00);
            check("rst_pred", {pred_valid, pred_taken}, 2'b00);
            m_q.delete();
            exp_pred_q.delete();
            m_sweep_left = N;
            m_wb         = 0;
            m_pred_due   = 0;
        end else begin
            model_step();
        end
    end

    // Scoreboard monitor: consumes one expected prediction per pred_valid.
    always @(negedge clk) begin
        if (rst_n && pred_valid) begin
            if (exp_pred_q.size() == 0) check("pred_unexpected", 1, 0);
            else check("pred_taken", pred_taken, exp_pred_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        lookup_req = 0; upd_valid = 0; flush_req = 0;
        repeat (n) tick();
    endtask

    task automatic wait_run(input int budget);
        int k = 0;
        while (busy_init && k < budget) begin tick(); k++; end
        check("sweep_done", busy_init, 0);
    endtask

    task automatic push_upd(input int idx, input bit taken);
        int k = 0;
        upd_valid = 1; upd_idx = idx[IDX_W-1:0]; upd_taken = taken;
        #1;
        while (!upd_ready && k < 20) begin tick(); k++; end
        check("push_accepted", upd_ready, 1);
        tick();
        upd_valid = 0;
    endtask

    task automatic lookup(input int idx);
        int k = 0;
        lookup_req = 1; lookup_idx = idx[IDX_W-1:0];
        #1;
        while (!lookup_gnt && k < 20) begin tick(); k++; end
        check("lookup_granted", lookup_gnt, 1);
        tick();
        lookup_req = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros, k, bad;
        for (int i = 0; i < N; i++) ram[i] = 2'($urandom_range(0, 3));
        rst_n = 0; lookup_req = 0; upd_valid = 0; flush_req = 0;
        lookup_idx = '0; upd_idx = '0; upd_taken = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Post-reset sweep, then the first lookup in the first run cycle.
        wait_run(200);
        lookup(5);
        idle(3);

        // Saturation up and down at idx 9.
        push_upd(9, 1);
        push_upd(9, 1);
        idle(6);
        lookup(9);
        push_upd(9, 1);
        idle(4);
        lookup(9);
        for (int i = 0; i < 4; i++) push_upd(9, 0);
        idle(10);
        lookup(9);
        idle(4);

        // Continuous lookups starve updates until the FIFO fills.
        lookup_req = 1;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1; upd_idx = 7'(20 + i); upd_taken = i[0];
            lookup_idx = 7'($urandom_range(0, N - 1));
            tick();
        end
        upd_valid = 0;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            lookup_idx = 7'($urandom_range(0, N - 1));
            #1;
            if (!lookup_gnt) zeros++;
            tick();
        end
        check("full_stall_cycles", zeros, 2);
        check("ready_after_drain", upd_ready, 1);
        idle(12);

        // Lookup ahead of a pending update sees the old value; after the write, the new one.
        push_upd(3, 1);
        lookup(3);
        idle(4);
        lookup(3);
        idle(4);

        // Flush during the write-back cycle.
        push_upd(40, 1);
        k = 0;
        while (!(tbl_en && tbl_we && !busy_init) && k < 20) begin tick(); k++; end
        check("write_seen", tbl_we, 1);
        flush_req = 1;
        tick();
        flush_req = 0;
        check("flush_enters_init", busy_init, 1);
        wait_run(200);
        check("fifo_empty_after_flush", tbl_en, 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== 2'd0) bad++;
        check("table_cleared", bad, 0);
        idle(2);

        // Random traffic with clustered indices and rare flushes.
        for (int c = 0; c < 1500; c++) begin
            lookup_req = 1'($urandom_range(0, 1));
            lookup_idx = 7'($urandom_range(0, 7));
            upd_valid  = 1'($urandom_range(0, 1));
            upd_idx    = 7'($urandom_range(0, 7));
            upd_taken  = 1'($urandom_range(0, 1));
            flush_req  = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle(10);
        wait_run(200);
        idle(6);

        // Reset mid-sweep at init_cnt 60.
        flush_req = 1;
        tick();
        flush_req = 0;
        k = 0;
        while (!(busy_init && tbl_addr == 7'd60) && k < 300) begin tick(); k++; end
        check("sweep_reached_60", tbl_addr, 60);
        #2 rst_n = 0;
        #1;
        check("async_rst_busy", busy_init, 1);
        check("async_rst_gnt_ready", {lookup_gnt, upd_ready}, 2'b00);
        check("async_rst_en_we", {tbl_en, tbl_we}, 2'b00);
        check("async_rst_pred", {pred_valid, pred_taken}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("sweep_restart_addr", tbl_addr, 0);
        wait_run(200);
        lookup(5);
        idle(6);

        check("scoreboard_drained", exp_pred_q.size(), 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== 2'(m_ctr[i])) bad++;
        check("table_matches_model", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
